// File: rtl/operand_stack.sv
// LIFO operand stack: registered TOS plus DEPTH-1 entry array, driven by a synchronous command strobe.
// Define STACK_ERR_FLAGS_EN to add sticky overflow/underflow flags and the clear_err input.
module operand_stack #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stack_clk,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_to_push,
`ifdef STACK_ERR_FLAGS_EN
    input  logic                       clear_err,
    output logic                       overflow,
    output logic                       underflow,
`endif
    output logic [WIDTH-1:0]           data_from_stack,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

    logic                 stk_q;
    logic                 fire;
    logic [WIDTH-1:0]     tos_q, tos_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 empty_q, full_q;
    logic [WIDTH-1:0]     mem_q [DEPTH-1];
    logic                 mem_we;
    logic [IdxW-1:0]      wr_idx, rd_idx;

    assign fire   = stack_clk & ~stk_q;
    // Entry below TOS lives at count-2; a push parks the old TOS at count-1.
    assign wr_idx = IdxW'(cnt_q - CntW'(1));
    assign rd_idx = IdxW'(cnt_q - CntW'(2));

    always_comb begin
        tos_d  = tos_q;
        cnt_d  = cnt_q;
        mem_we = 1'b0;
        if (fire) begin
            unique case ({push, pop})
                2'b10: begin
                    if (!full_q) begin
                        mem_we = !empty_q;
                        tos_d  = data_to_push;
                        cnt_d  = cnt_q + CntW'(1);
                    end
                end
                2'b01: begin
                    if (!empty_q) begin
                        tos_d = (cnt_q == CntW'(1)) ? '0 : mem_q[rd_idx];
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                2'b11: begin
                    tos_d = data_to_push;
                    if (empty_q) begin
                        cnt_d = CntW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stk_q   <= 1'b0;
            tos_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            stk_q   <= stack_clk;
            tos_q   <= tos_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CntW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem_q[wr_idx] <= tos_q;
        end
    end

    assign data_from_stack = tos_q;
    assign count           = cnt_q;
    assign empty           = empty_q;
    assign full            = full_q;

`ifdef STACK_ERR_FLAGS_EN
    logic ovf_q, unf_q;
    logic ovf_evt, unf_evt;

    // A push+pop on an empty stack still counts as an underflow.
    assign ovf_evt = fire & push & ~pop & full_q;
    assign unf_evt = fire & pop & empty_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_evt | (ovf_q & ~clear_err);
            unf_q <= unf_evt | (unf_q & ~clear_err);
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_operand_stack.sv
// Randomised bench for operand_stack against a queue-based LIFO model, plus directed literal checks.
module tb_operand_stack;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             stack_clk = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] data_to_push = '0;
    logic [WIDTH-1:0] data_from_stack;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
`ifdef STACK_ERR_FLAGS_EN
    logic             clear_err = 1'b0;
    logic             overflow;
    logic             underflow;
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    bit          chk_en = 1'b0;
    logic [WIDTH-1:0] mstk[$];
    bit          m_stk = 1'b0;

    always #5 clk = ~clk;

    operand_stack #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stack_clk      (stack_clk),
        .push           (push),
        .pop            (pop),
        .data_to_push   (data_to_push),
`ifdef STACK_ERR_FLAGS_EN
        .clear_err      (clear_err),
        .overflow       (overflow),
        .underflow      (underflow),
`endif
        .data_from_stack(data_from_stack),
        .count          (count),
        .empty          (empty),
        .full           (full)
    );

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    function automatic int model_tos();
        return (mstk.size() == 0) ? 0 : int'(mstk[mstk.size()-1]);
    endfunction

    // Reference: a queue holding the stack, bottom at index 0.
    always @(posedge clk) begin
        bit fire;
        bit ovf_e;
        bit unf_e;
        ovf_e = 1'b0;
        unf_e = 1'b0;
        if (!reset) begin
            mstk.delete();
            m_stk = 1'b0;
`ifdef STACK_ERR_FLAGS_EN
            m_ovf = 1'b0;
            m_unf = 1'b0;
`endif
        end else begin
            fire  = stack_clk && !m_stk;
            m_stk = stack_clk;
            if (fire) begin
                if (push && !pop) begin
                    if (mstk.size() == DEPTH) ovf_e = 1'b1;
                    else mstk.push_back(data_to_push);
                end else if (pop && !push) begin
                    if (mstk.size() == 0) unf_e = 1'b1;
                    else void'(mstk.pop_back());
                end else if (push && pop) begin
                    if (mstk.size() == 0) begin
                        unf_e = 1'b1;
                        mstk.push_back(data_to_push);
                    end else begin
                        mstk[mstk.size()-1] = data_to_push;
                    end
                end
            end
`ifdef STACK_ERR_FLAGS_EN
            m_ovf = ovf_e || (m_ovf && !clear_err);
            m_unf = unf_e || (m_unf && !clear_err);
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tos", int'(data_from_stack), model_tos());
            check("count", int'(count), mstk.size());
            check("empty", int'(empty), int'(mstk.size() == 0));
            check("full", int'(full), int'(mstk.size() == DEPTH));
`ifdef STACK_ERR_FLAGS_EN
            check("overflow", int'(overflow), int'(m_ovf));
            check("underflow", int'(underflow), int'(m_unf));
`endif
        end
    end

    task automatic cmd(input bit pu, input bit po, input logic [WIDTH-1:0] d);
        @(negedge clk);
        stack_clk    = 1'b1;
        push         = pu;
        pop          = po;
        data_to_push = d;
        @(negedge clk);
        stack_clk    = 1'b0;
        push         = 1'($urandom);
        pop          = 1'($urandom);
        data_to_push = WIDTH'($urandom);
    endtask

`ifdef STACK_ERR_FLAGS_EN
    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask
`endif

    initial begin
        // Reset with the strobe toggling underneath it.
        push = 1'b1;
        repeat (2) begin
            @(negedge clk);
            stack_clk = ~stack_clk;
        end
        @(negedge clk);
        stack_clk = 1'b0;
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_tos", int'(data_from_stack), 0);
`ifdef STACK_ERR_FLAGS_EN
        check("rst_ovf", int'(overflow), 0);
        check("rst_unf", int'(underflow), 0);
`endif
        reset  = 1'b1;
        chk_en = 1'b1;

        cmd(1, 0, 8'h11);
        cmd(1, 0, 8'h22);
        cmd(1, 0, 8'h33);
        check("lifo_tos", int'(data_from_stack), 8'h33);
        check("lifo_count", int'(count), 3);
        cmd(0, 1, 8'h00);
        check("lifo_pop1", int'(data_from_stack), 8'h22);
        cmd(0, 1, 8'h00);
        check("lifo_pop2", int'(data_from_stack), 8'h11);
        cmd(0, 1, 8'h00);
        check("lifo_pop3", int'(data_from_stack), 8'h00);
        check("lifo_empty", int'(empty), 1);

        @(negedge clk);
        stack_clk    = 1'b1;
        push         = 1'b1;
        pop          = 1'b0;
        data_to_push = 8'hA5;
        repeat (5) @(negedge clk);
        stack_clk = 1'b0;
        check("held_count", int'(count), 1);
        check("held_tos", int'(data_from_stack), 8'hA5);
        cmd(0, 1, 8'h00);

        for (int i = 0; i < DEPTH; i++) cmd(1, 0, WIDTH'(i));
        check("fill_full", int'(full), 1);
        check("fill_tos", int'(data_from_stack), 8'h0F);
        cmd(1, 0, 8'h99);
        check("ovf_count", int'(count), DEPTH);
        check("ovf_tos", int'(data_from_stack), 8'h0F);
`ifdef STACK_ERR_FLAGS_EN
        check("ovf_flag", int'(overflow), 1);
        pulse_clear();
        check("ovf_clear", int'(overflow), 0);
`endif
        for (int i = 0; i < DEPTH; i++) cmd(0, 1, 8'h00);
        check("drain_empty", int'(empty), 1);
        cmd(0, 1, 8'h00);
        check("unf_count", int'(count), 0);
`ifdef STACK_ERR_FLAGS_EN
        check("unf_flag", int'(underflow), 1);
`endif
        cmd(1, 1, 8'h42);
        check("pp_empty_count", int'(count), 1);
        check("pp_empty_tos", int'(data_from_stack), 8'h42);
`ifdef STACK_ERR_FLAGS_EN
        check("pp_empty_unf", int'(underflow), 1);
        pulse_clear();
`endif
        cmd(0, 1, 8'h00);

        cmd(1, 0, 8'h05);
        cmd(1, 0, 8'h07);
        cmd(1, 1, 8'h09);
        check("replace_tos", int'(data_from_stack), 8'h09);
        check("replace_count", int'(count), 2);
`ifdef STACK_ERR_FLAGS_EN
        check("replace_ovf", int'(overflow), 0);
        check("replace_unf", int'(underflow), 0);
`endif
        cmd(0, 1, 8'h00);
        check("replace_below", int'(data_from_stack), 8'h05);

        // Reset wins over a fired push; the still-high strobe fires once afterwards.
        @(negedge clk);
        reset        = 1'b0;
        stack_clk    = 1'b1;
        push         = 1'b1;
        pop          = 1'b0;
        data_to_push = 8'h77;
        @(negedge clk);
        check("rstpri_count", int'(count), 0);
        reset = 1'b1;
        @(negedge clk);
        check("rstpost_count", int'(count), 1);
        check("rstpost_tos", int'(data_from_stack), 8'h77);
        stack_clk = 1'b0;

        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1200; i++) begin
                @(negedge clk);
                stack_clk    = 1'($urandom_range(0, 1));
                push         = ($urandom_range(0, 99) < ((ph == 0) ? 70 : 30));
                pop          = ($urandom_range(0, 99) < ((ph == 0) ? 30 : 70));
                data_to_push = WIDTH'($urandom);
`ifdef STACK_ERR_FLAGS_EN
                clear_err    = ($urandom_range(0, 19) == 0);
`endif
                reset        = ($urandom_range(0, 299) != 0);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        stack_clk = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
